// File: rtl/interrupt_controller_pkg.sv
// Shared constants, IME state encoding and vector helper
// for the interrupt controller.
package interrupt_controller_pkg;

    localparam logic [15:0] IF_ADDR = 16'hFF0F;
    localparam logic [15:0] IE_ADDR = 16'hFFFF;

    localparam logic [7:0] VEC_BASE   = 8'h40;
    localparam logic [7:0] VEC_STRIDE = 8'h08;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    typedef enum logic [1:0] {
        IME_OFF  = 2'd0,
        IME_ARM1 = 2'd1,
        IME_ARM2 = 2'd2,
        IME_ON   = 2'd3
    } ime_state_t;

    function automatic logic [7:0] vec_addr(input logic [7:0] idx);
        return VEC_BASE + VEC_STRIDE * idx;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-first selector: one-hot of the first set bit,
// its binary index, and a valid flag.
module priority_encoder #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = |req;
        // Walk downward so the lowest set bit is the last to win.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE registers, IME sequencing with the EI delay,
// and dispatch vector generation.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ = 5
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Enable,
    input  logic [NUM_IRQ-1:0] i_Request,
    input  logic [15:0]        i_Addr,
    input  logic               i_Read,
    input  logic               i_Write,
    input  logic [7:0]         i_Data,
    output logic [7:0]         o_Data,
    input  logic               i_EI,
    input  logic               i_DI,
    input  logic               i_RETI,
    input  logic               i_Instr_Boundary,
    input  logic               i_Handle_Interrupt,
    output logic [NUM_IRQ-1:0] o_Pending,
    output logic               o_Irq_Request,
    output logic [7:0]         o_Vector,
    output logic               o_IME
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] if_q;
    logic [7:0]         ie_q;
    ime_state_t         state;

    logic [NUM_IRQ-1:0] sel_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [7:0]         sel_idx8;
    logic [NUM_IRQ-1:0] if_next;
    logic [7:0]         rd_if;

    assign o_Pending     = ie_q[NUM_IRQ-1:0] & if_q;
    assign o_IME         = (state == IME_ON);
    assign o_Irq_Request = o_IME & (|o_Pending);

    priority_encoder #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req    (o_Pending),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .valid  (sel_valid)
    );

    always_comb begin
        sel_idx8 = '0;
        sel_idx8[IDX_W-1:0] = sel_idx;
    end

    // Write, then ack clear, then requests: a new request always wins.
    always_comb begin
        if_next = if_q;
        if (i_Write && i_Addr == IF_ADDR)
            if_next = i_Data[NUM_IRQ-1:0];
        if (i_Handle_Interrupt && sel_valid)
            if_next = if_next & ~sel_onehot;
        if_next = if_next | i_Request;
    end

    always_comb begin
        rd_if = '1;
        rd_if[NUM_IRQ-1:0] = if_q;
        o_Data = '0;
        if (i_Read) begin
            if (i_Addr == IF_ADDR)
                o_Data = rd_if;
            else if (i_Addr == IE_ADDR)
                o_Data = ie_q;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            if_q     <= '0;
            ie_q     <= '0;
            state    <= IME_OFF;
            o_Vector <= '0;
        end else if (i_Enable) begin
            if_q <= if_next;
            if (i_Write && i_Addr == IE_ADDR)
                ie_q <= i_Data;

            if (i_Handle_Interrupt) begin
                o_Vector <= sel_valid ? vec_addr(sel_idx8) : 8'h00;
                state    <= IME_OFF;
            end else if (i_DI) begin
                state <= IME_OFF;
            end else if (i_RETI) begin
                state <= IME_ON;
            end else begin
                unique case (state)
                    IME_OFF:  if (i_EI) state <= IME_ARM1;
                    IME_ARM1: if (i_Instr_Boundary) state <= IME_ARM2;
                    IME_ARM2: if (i_Instr_Boundary) state <= IME_ON;
                    IME_ON:   state <= IME_ON;
                    default:  state <= IME_OFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
// Expected values are hand-computed constants.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [4:0]  req = '0;
    logic [15:0] addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        ei = 1'b0;
    logic        di = 1'b0;
    logic        reti = 1'b0;
    logic        bnd = 1'b0;
    logic        ack = 1'b0;
    logic [4:0]  pending;
    logic        irq;
    logic [7:0]  vector;
    logic        ime;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    interrupt_controller #(.NUM_IRQ(5)) dut (
        .i_Clk              (clk),
        .i_Rst              (rst),
        .i_Enable           (en),
        .i_Request          (req),
        .i_Addr             (addr),
        .i_Read             (rd),
        .i_Write            (wr),
        .i_Data             (wdata),
        .o_Data             (rdata),
        .i_EI               (ei),
        .i_DI               (di),
        .i_RETI             (reti),
        .i_Instr_Boundary   (bnd),
        .i_Handle_Interrupt (ack),
        .o_Pending          (pending),
        .o_Irq_Request      (irq),
        .o_Vector           (vector),
        .o_IME              (ime)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req = '0; wr = 1'b0; rd = 1'b0; ei = 1'b0; di = 1'b0;
        reti = 1'b0; bnd = 1'b0; ack = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        step();
        clr();
    endtask

    task automatic bus_rd(input string tag, input logic [15:0] a,
                          input logic [7:0] exp);
        addr = a; rd = 1'b1;
        #1;
        chk(tag, {8'h00, rdata}, {8'h00, exp});
        rd = 1'b0;
    endtask

    initial begin
        clr();
        step();
        step();
        chk("rst_pending", {11'd0, pending}, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        chk("rst_vector", {8'd0, vector}, 16'h0000);
        chk("rst_ime", {15'd0, ime}, 16'h0000);
        rst = 1'b0;
        step();
        bus_rd("rst_if", 16'hFF0F, 8'hE0);
        bus_rd("rst_ie", 16'hFFFF, 8'h00);
        addr = 16'hFF0F;
        #1;
        chk("unselected_data", {8'd0, rdata}, 16'h0000);

        // Timer request, RETI, dispatch
        bus_wr(16'hFFFF, 8'h05);
        bus_rd("ie_rd", 16'hFFFF, 8'h05);
        req = 5'h04; step(); clr();
        chk("t_pending", {11'd0, pending}, 16'h0004);
        bus_rd("t_if", 16'hFF0F, 8'hE4);
        chk("t_irq_off", {15'd0, irq}, 16'h0000);
        reti = 1'b1; step(); clr();
        chk("t_irq_on", {15'd0, irq}, 16'h0001);
        ack = 1'b1; step(); clr();
        chk("t_vector", {8'd0, vector}, 16'h0050);
        bus_rd("t_if_clr", 16'hFF0F, 8'hE0);
        chk("t_ime_off", {15'd0, ime}, 16'h0000);

        // All sources pending: dispatch in priority order
        bus_wr(16'hFF0F, 8'h1F);
        bus_wr(16'hFFFF, 8'h1F);
        reti = 1'b1; step(); clr();
        for (int k = 0; k < 5; k++) begin
            chk("all_irq", {15'd0, irq}, 16'h0001);
            ack = 1'b1; step(); clr();
            chk("all_vector", {8'd0, vector}, 16'(8'h40 + 8 * k));
            reti = 1'b1; step(); clr();
        end
        chk("all_pending", {11'd0, pending}, 16'h0000);
        chk("all_irq_none", {15'd0, irq}, 16'h0000);

        // EI delay of one instruction
        di = 1'b1; step(); clr();
        chk("di_ime", {15'd0, ime}, 16'h0000);
        req = 5'h01; step(); clr();
        ei = 1'b1; step(); clr();
        chk("ei_arm1", {15'd0, irq}, 16'h0000);
        bnd = 1'b1; step(); clr();
        chk("ei_arm2", {15'd0, irq}, 16'h0000);
        bnd = 1'b1; step(); clr();
        chk("ei_on", {15'd0, irq}, 16'h0001);
        di = 1'b1; step(); clr();
        ei = 1'b1; di = 1'b1; step(); clr();
        bnd = 1'b1; step(); clr();
        bnd = 1'b1; step(); clr();
        chk("ei_di_off", {15'd0, ime}, 16'h0000);

        // Request beats a same-cycle IF write and an ack clear
        addr = 16'hFF0F; wdata = 8'h00; wr = 1'b1; req = 5'h01;
        step(); clr();
        bus_rd("wr_vs_req", 16'hFF0F, 8'hE1);
        reti = 1'b1; step(); clr();
        ack = 1'b1; req = 5'h01; step(); clr();
        chk("ack_rereq_vec", {8'd0, vector}, 16'h0040);
        bus_rd("ack_rereq_if", 16'hFF0F, 8'hE1);
        chk("ack_rereq_ime", {15'd0, ime}, 16'h0000);
        bus_wr(16'hFF0F, 8'h00);

        // Pending without IME, ack with IE cleared in flight
        bus_wr(16'hFFFF, 8'h10);
        req = 5'h10; step(); clr();
        chk("halt_pending", {11'd0, pending}, 16'h0010);
        chk("halt_irq", {15'd0, irq}, 16'h0000);
        bus_wr(16'hFFFF, 8'h00);
        ack = 1'b1; step(); clr();
        chk("null_vector", {8'd0, vector}, 16'h0000);
        bus_rd("null_if", 16'hFF0F, 8'hF0);

        // Ack together with EI ends in OFF
        bus_wr(16'hFFFF, 8'h10);
        reti = 1'b1; step(); clr();
        ack = 1'b1; ei = 1'b1; step(); clr();
        chk("ack_ei_vec", {8'd0, vector}, 16'h0060);
        bnd = 1'b1; step(); clr();
        bnd = 1'b1; step(); clr();
        chk("ack_ei_ime", {15'd0, ime}, 16'h0000);

        // Clock enable gates state changes
        en = 1'b0;
        req = 5'h01; reti = 1'b1; step(); clr();
        en = 1'b1;
        bus_rd("en_if", 16'hFF0F, 8'hE0);
        chk("en_ime", {15'd0, ime}, 16'h0000);

        // Asynchronous reset in ARM2
        bus_wr(16'hFF0F, 8'h1F);
        bus_wr(16'hFFFF, 8'h1F);
        ei = 1'b1; step(); clr();
        bnd = 1'b1; step(); clr();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pending", {11'd0, pending}, 16'h0000);
        chk("arst_irq", {15'd0, irq}, 16'h0000);
        chk("arst_vector", {8'd0, vector}, 16'h0000);
        chk("arst_ime", {15'd0, ime}, 16'h0000);
        step();
        rst = 1'b0;
        bus_rd("arst_if", 16'hFF0F, 8'hE0);
        bnd = 1'b1; step(); clr();
        bnd = 1'b1; step(); clr();
        chk("arst_stay_off", {15'd0, ime}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 5, number of interrupt sources (0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad).
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 SHALL have port i_Clk, input, 1, system clock.
REQ-004 SHALL have port i_Rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_Enable, input, 1, clock enable; all state changes are gated by it.
REQ-006 SHALL have port i_Request, input, 5, peripheral request pulses, one per source.
REQ-007 SHALL have port i_Addr, input, 16, memory bus address.
REQ-008 SHALL have port i_Read, input, 1, memory read strobe.
REQ-009 SHALL have port i_Write, input, 1, memory write strobe.
REQ-010 SHALL have port i_Data, input, 8, write data.
REQ-011 SHALL have port o_Data, output, 8, read data; 0 when not selected, so it can be OR-combined onto the bus.
REQ-012 SHALL have port i_EI, input, 1, pulse from the control unit while EI executes.
REQ-013 SHALL have port i_DI, input, 1, pulse from the control unit while DI executes.
REQ-014 SHALL have port i_RETI, input, 1, pulse from the control unit while RETI executes.
REQ-015 SHALL have port i_Instr_Boundary, input, 1, one-cycle pulse at each opcode-fetch start.
REQ-016 SHALL have port i_Handle_Interrupt, input, 1, dispatch acknowledge from the control unit.
REQ-017 SHALL have port o_Pending, output, 5, IE & IF; drives the control unit's i_Interrupts (HALT wake, independent of IME).
REQ-018 SHALL have port o_Irq_Request, output, 1, (IME state ON) & |o_Pending.
REQ-019 SHALL have port o_Vector, output, 8, registered low byte of the dispatch address.
REQ-020 SHALL have port o_IME, output, 1, high only in state ON.

Function
REQ-021 IF[4:0] SHALL set bit n on any enabled cycle with i_Request[n]=1.
REQ-022 A write with i_Addr=0xFF0F SHALL load IF from i_Data[4:0]; a same-cycle request for bit n SHALL win (bit stays 1).
REQ-023 A read with i_Addr=0xFF0F SHALL return {3'b111, IF}.
REQ-024 IE SHALL be 8 bits at 0xFFFF and fully read/write; only IE[4:0] feeds o_Pending.
REQ-025 The IME state machine SHALL have states OFF, ARM1, ARM2 and ON.
REQ-026 i_EI in OFF SHALL move the machine to ARM1; i_EI in ARM1, ARM2 or ON SHALL be ignored.
REQ-027 A boundary in ARM1 SHALL move to ARM2; a boundary in ARM2 SHALL move to ON, so IME takes effect after the instruction following EI.
REQ-028 i_DI SHALL move any state to OFF on the next enabled edge; if i_DI and i_EI arrive together, DI wins.
REQ-029 i_RETI SHALL move any state directly to ON.
REQ-030 On i_Handle_Interrupt, the block SHALL clear the lowest-index set bit of o_Pending in IF, latch o_Vector = 0x40 + 8*index, and set state OFF, all in one edge.
REQ-031 If an ack arrives with o_Pending = 0 (IE cleared in flight), o_Vector SHALL be 0x00 and IF SHALL be unchanged.
REQ-032 If an ack clears bit n and i_Request[n] is asserted in the same cycle, IF[n] SHALL remain 1.
REQ-033 If an ack and i_EI arrive together, the state SHALL become OFF.
REQ-034 o_Pending and o_Irq_Request SHALL be combinational from registered state, with zero-cycle latency.

Reset
REQ-035 Asserting i_Rst at any time SHALL immediately force IF=0, IE=0, state OFF, o_Vector=0x00, o_Pending=0, o_Irq_Request=0 and o_IME=0, abandoning any in-flight EI delay.
REQ-036 The block SHALL resume on the first enabled edge after i_Rst deasserts.

Structure
REQ-037 A shared package SHALL hold the IF/IE addresses (0xFF0F, 0xFFFF), vector base 0x40, vector stride 8, the IME state encoding and the source bit indices.
REQ-038 Lowest-index selection SHALL be one sub-module, priority_encoder (5-bit one-hot-first plus valid); all other logic stays in interrupt_controller.

Verification
REQ-039 IE=0x05, pulse i_Request=0x04 -> IF=0x04, o_Pending=0x04; RETI -> o_Irq_Request=1; ack -> o_Vector=0x50, IF=0x00, o_IME=0.
REQ-040 IF=0x1F, IE=0x1F, IME ON -> successive acks (RETI between) give vectors 0x40, 0x48, 0x50, 0x58, 0x60.
REQ-041 Pulse EI then two boundaries, with pending non-zero -> o_Irq_Request=0 after the first boundary, 1 after the second; EI+DI in the same cycle -> stays OFF.
REQ-042 Write 0x00 to 0xFF0F with i_Request[0]=1 in the same cycle -> read of 0xFF0F returns 0xE1; ack on bit 0 with re-request -> IF[0]=1.
REQ-043 IME OFF, IE=0x10, request 0x10 -> o_Pending=0x10, o_Irq_Request=0; ack with IE=0 -> o_Vector=0x00.
REQ-044 Assert i_Rst in ARM2 with IF=0x1F -> all outputs 0 asynchronously; after release, a boundary leaves the state OFF.
